// File: rtl/picobus_stream_target.sv
// PicoBus target bridging a DATA register to 128b TX/RX streams through two FWFT FIFOs.
// Optional STATS register at offset 0x40 when STREAM_TARGET_STATS_EN is defined.

module picobus_stream_fifo #(
    parameter int W  = 128,
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic          pop,
    input  logic          flush,
    input  logic [W-1:0]  din,
    output logic [W-1:0]  dout,
    output logic [AW:0]   count,
    output logic          full,
    output logic          empty
);
    logic [W-1:0] mem [2**AW];
    logic [AW:0]  wptr, rptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr <= '0;
            rptr <= '0;
        end else if (flush) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush) mem[wptr[AW-1:0]] <= din;
    end

    assign dout  = mem[rptr[AW-1:0]];
    assign count = wptr - rptr;
    // Extra pointer bit distinguishes full from empty when the indices match.
    assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign empty = (wptr == rptr);
endmodule

module picobus_stream_target #(
    parameter logic [31:0] BASE_ADDR       = 32'h0001_0000,
    parameter int          FIFO_DEPTH_LOG2 = 4,
    parameter logic [31:0] ID_VALUE        = 32'h5053_5431
) (
    input  logic         PicoClk,
    input  logic         PicoRst_n,
    input  logic [31:0]  PicoAddr,
    input  logic [127:0] PicoDataIn,
    input  logic         PicoWr,
    input  logic         PicoRd,
    output logic [127:0] PicoDataOut,
    output logic         m_valid,
    input  logic         m_ready,
    output logic [127:0] m_data,
    input  logic         s_valid,
    output logic         s_ready,
    input  logic [127:0] s_data
);
    localparam int CW = FIFO_DEPTH_LOG2 + 1;

    typedef struct packed {
        logic       wr;
        logic       rd;
        logic [3:0] off;
    } bus_req_t;

    bus_req_t     req;
    logic         sel;
    logic         unused_addr_bits;
    logic         tx_push, tx_pop, tx_full, tx_empty, tx_ovf;
    logic         rx_push, rx_pop, rx_full, rx_empty, rx_udf;
    logic         data_wr, data_rd, ctl_wr, flush_tx, flush_rx, clr;
    logic [CW-1:0] tx_count, rx_count;
    logic [127:0] rx_head, status, rd_mux;

    assign sel     = (PicoAddr[31:8] == BASE_ADDR[31:8]);
    assign req     = '{wr: PicoWr && sel, rd: PicoRd && sel, off: PicoAddr[7:4]};
    assign unused_addr_bits = ^PicoAddr[3:0];

    assign data_wr  = req.wr && (req.off == 4'h0);
    assign data_rd  = req.rd && (req.off == 4'h0);
    assign ctl_wr   = req.wr && (req.off == 4'h2);
    assign flush_tx = ctl_wr && PicoDataIn[0];
    assign flush_rx = ctl_wr && PicoDataIn[1];
    assign clr      = ctl_wr && PicoDataIn[2];

    // Fullness/emptiness are sampled before same-cycle stream activity.
    assign tx_push = data_wr && !tx_full;
    assign tx_pop  = !tx_empty && m_ready;
    assign rx_push = s_valid && !rx_full;
    assign rx_pop  = data_rd && !rx_empty;

    assign m_valid = !tx_empty;
    assign s_ready = !rx_full;

    picobus_stream_fifo #(.W(128), .AW(FIFO_DEPTH_LOG2)) u_tx (
        .clk(PicoClk), .rst_n(PicoRst_n), .push(tx_push), .pop(tx_pop), .flush(flush_tx),
        .din(PicoDataIn), .dout(m_data), .count(tx_count), .full(tx_full), .empty(tx_empty)
    );

    picobus_stream_fifo #(.W(128), .AW(FIFO_DEPTH_LOG2)) u_rx (
        .clk(PicoClk), .rst_n(PicoRst_n), .push(rx_push), .pop(rx_pop), .flush(flush_rx),
        .din(s_data), .dout(rx_head), .count(rx_count), .full(rx_full), .empty(rx_empty)
    );

    // A flag event in the same cycle as a clear is kept (clear then set).
    always_ff @(posedge PicoClk or negedge PicoRst_n) begin
        if (!PicoRst_n) begin
            tx_ovf <= 1'b0;
            rx_udf <= 1'b0;
        end else begin
            tx_ovf <= (tx_ovf && !clr) || (data_wr && tx_full);
            rx_udf <= (rx_udf && !clr) || (data_rd && rx_empty);
        end
    end

`ifdef STREAM_TARGET_STATS_EN
    logic [63:0] st_tx, st_rx;

    always_ff @(posedge PicoClk or negedge PicoRst_n) begin
        if (!PicoRst_n) begin
            st_tx <= '0;
            st_rx <= '0;
        end else begin
            st_tx <= (clr ? 64'd0 : st_tx) + {63'd0, tx_push && !flush_tx};
            st_rx <= (clr ? 64'd0 : st_rx) + {63'd0, rx_pop};
        end
    end
`endif

    assign status = {92'd0, rx_udf, tx_ovf, rx_empty, tx_full,
                     16'(rx_count), 16'(tx_count)};

    always_comb begin
        rd_mux = '0;
        case (req.off)
            4'h0: rd_mux = rx_empty ? '0 : rx_head;
            4'h1: rd_mux = status;
            4'h3: rd_mux = {96'd0, ID_VALUE};
`ifdef STREAM_TARGET_STATS_EN
            4'h4: rd_mux = {st_rx, st_tx};
`endif
            default: rd_mux = '0;
        endcase
    end

    // Zero whenever not answering a selected read, so targets can be ORed.
    always_ff @(posedge PicoClk or negedge PicoRst_n) begin
        if (!PicoRst_n) PicoDataOut <= '0;
        else            PicoDataOut <= req.rd ? rd_mux : '0;
    end
endmodule

// File: tb/tb_picobus_stream_target.sv
// Self-checking bench: queue-based reference model, per-cycle compare, directed literals, random traffic.
// Honors STREAM_TARGET_STATS_EN for the STATS register expectation.

module tb_picobus_stream_target;
    localparam logic [31:0] BASE = 32'h0001_0000;

    logic         PicoClk = 1'b0;
    logic         PicoRst_n = 1'b0;
    logic [31:0]  PicoAddr = '0;
    logic [127:0] PicoDataIn = '0;
    logic         PicoWr = 1'b0, PicoRd = 1'b0;
    logic [127:0] PicoDataOut;
    logic         m_valid, m_ready = 1'b0;
    logic [127:0] m_data;
    logic         s_valid = 1'b0, s_ready;
    logic [127:0] s_data = '0;

    int ntests = 0, nfail = 0;

    picobus_stream_target dut (
        .PicoClk(PicoClk), .PicoRst_n(PicoRst_n), .PicoAddr(PicoAddr),
        .PicoDataIn(PicoDataIn), .PicoWr(PicoWr), .PicoRd(PicoRd),
        .PicoDataOut(PicoDataOut), .m_valid(m_valid), .m_ready(m_ready),
        .m_data(m_data), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data)
    );

    initial forever #5 PicoClk = ~PicoClk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        ntests++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference model: stream FIFOs as queues, flags and counters as plain variables.
    logic [127:0] txq[$], rxq[$];
    bit           f_ovf = 0, f_udf = 0;
    logic [63:0]  n_tx = '0, n_rx = '0;
    logic [127:0] exp_rd = '0;

    function automatic logic [127:0] model_status();
        return {92'd0, f_udf, f_ovf, rxq.size() == 0, txq.size() == 16,
                16'(rxq.size()), 16'(txq.size())};
    endfunction

    initial forever begin
        @(posedge PicoClk or negedge PicoRst_n);
        if (!PicoRst_n) begin
            txq.delete(); rxq.delete();
            f_ovf = 0; f_udf = 0; n_tx = '0; n_rx = '0; exp_rd = '0;
        end else begin
            automatic bit sel = (PicoAddr[31:8] == BASE[31:8]);
            automatic int off = int'(PicoAddr[7:4]);
            automatic bit dw  = sel && PicoWr && off == 0;
            automatic bit dr  = sel && PicoRd && off == 0;
            automatic bit cw  = sel && PicoWr && off == 2;
            automatic bit ovf = dw && txq.size() == 16;
            automatic bit udf = dr && rxq.size() == 0;
            automatic bit push_tx = dw && !ovf;
            automatic bit pop_tx  = txq.size() != 0 && m_ready;
            automatic bit push_rx = s_valid && rxq.size() < 16;
            automatic bit pop_rx  = dr && rxq.size() != 0;
            automatic bit ftx = cw && PicoDataIn[0];
            automatic bit frx = cw && PicoDataIn[1];
            automatic bit clr = cw && PicoDataIn[2];
            automatic logic [127:0] rd = '0;
            if (sel && PicoRd) begin
                case (off)
                    0: rd = (rxq.size() != 0) ? rxq[0] : '0;
                    1: rd = model_status();
                    3: rd = {96'd0, 32'h5053_5431};
`ifdef STREAM_TARGET_STATS_EN
                    4: rd = {n_rx, n_tx};
`endif
                    default: rd = '0;
                endcase
            end
            if (pop_tx)  void'(txq.pop_front());
            if (push_tx) txq.push_back(PicoDataIn);
            if (pop_rx)  void'(rxq.pop_front());
            if (push_rx) rxq.push_back(s_data);
            if (ftx) txq.delete();
            if (frx) rxq.delete();
            if (clr) begin f_ovf = 0; f_udf = 0; n_tx = '0; n_rx = '0; end
            if (ovf) f_ovf = 1;
            if (udf) f_udf = 1;
            if (push_tx && !ftx) n_tx = n_tx + 64'd1;
            if (pop_rx) n_rx = n_rx + 64'd1;
            exp_rd = rd;
        end
    end

    // Compare process: all outputs against the model, every cycle out of reset.
    initial forever begin
        @(negedge PicoClk);
        if (PicoRst_n) begin
            chk("m_valid", 128'(m_valid), 128'(txq.size() != 0));
            if (txq.size() != 0) chk("m_data", m_data, txq[0]);
            chk("s_ready", 128'(s_ready), 128'(rxq.size() < 16));
            chk("PicoDataOut", PicoDataOut, exp_rd);
        end
    end

    task automatic tick();
        @(negedge PicoClk);
        #1;
    endtask

    task automatic do_write(input logic [31:0] a, input logic [127:0] d);
        PicoAddr = a; PicoDataIn = d; PicoWr = 1'b1;
        tick();
        PicoWr = 1'b0;
    endtask

    task automatic do_read(input logic [31:0] a, output logic [127:0] d);
        PicoAddr = a; PicoRd = 1'b1;
        tick();
        PicoRd = 1'b0;
        d = PicoDataOut;
    endtask

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    initial begin
        logic [127:0] d;
        tick(); tick();
        chk("rst_m_valid", 128'(m_valid), 128'd0);
        chk("rst_s_ready", 128'(s_ready), 128'd1);
        chk("rst_rdata", PicoDataOut, 128'd0);
        PicoRst_n = 1'b1;
        tick();
        do_read(BASE + 32'h10, d); chk("status_reset", d, 128'h2_0000_0000);

        // three TX beats held, then drained in order
        m_ready = 1'b0;
        do_write(BASE, 128'hA); do_write(BASE, 128'hB); do_write(BASE, 128'hC);
        chk("tx_head", m_data, 128'hA);
        do_read(BASE + 32'h10, d); chk("status_tx3", d, 128'h2_0000_0003);
        m_ready = 1'b1;
        chk("tx_out0", m_data, 128'hA); tick();
        chk("tx_out1", m_data, 128'hB); tick();
        chk("tx_out2", m_data, 128'hC); tick();
        m_ready = 1'b0;
        chk("tx_drained", 128'(m_valid), 128'd0);

        // fill RX, then read it empty plus one underflow
        for (int i = 1; i <= 16; i++) begin
            s_valid = 1'b1; s_data = 128'(i); tick();
        end
        s_valid = 1'b0;
        chk("rx_full_sready", 128'(s_ready), 128'd0);
        do_read(BASE + 32'h10, d); chk("status_rx16", d, 128'h10_0000);
        for (int i = 1; i <= 17; i++) begin
            do_read(BASE, d);
            chk("rx_read", d, (i <= 16) ? 128'(i) : 128'd0);
        end
        do_read(BASE + 32'h10, d); chk("status_udf", d, 128'hA_0000_0000);

        // TX overflow, then flush TX + clear flags
        for (int i = 0; i < 17; i++) do_write(BASE, 128'(100 + i));
        do_read(BASE + 32'h10, d); chk("status_ovf", d, 128'hF_0000_0010);
        do_write(BASE + 32'h20, 128'h5);
        do_read(BASE + 32'h10, d); chk("status_clr", d, 128'h2_0000_0000);

        // ID and out-of-window
        do_read(BASE + 32'h3C, d); chk("id", d, 128'h5053_5431);
        do_read(32'h0002_0000, d); chk("oow_rd", d, 128'd0);
        tick(); chk("oow_next", PicoDataOut, 128'd0);

        // stats
        for (int i = 0; i < 5; i++) do_write(BASE, 128'(200 + i));
        s_valid = 1'b1; s_data = 128'd7; tick(); s_data = 128'd8; tick(); s_valid = 1'b0;
        do_read(BASE, d); chk("rx_pop7", d, 128'd7);
        do_read(BASE, d); chk("rx_pop8", d, 128'd8);
        do_read(BASE + 32'h40, d);
`ifdef STREAM_TARGET_STATS_EN
        chk("stats", d, {64'd2, 64'd5});
`else
        chk("stats_absent", d, 128'd0);
`endif
        do_write(BASE + 32'h20, 128'h3);
        do_read(BASE + 32'h10, d); chk("status_flush", d, 128'h2_0000_0000);

        // asynchronous reset mid-traffic
        do_write(BASE, 128'h11); do_write(BASE, 128'h22);
        s_valid = 1'b1; s_data = 128'h55; tick(); tick();
        PicoAddr = BASE + 32'h10; PicoRd = 1'b1;
        #2 PicoRst_n = 1'b0;
        #1;
        chk("arst_m_valid", 128'(m_valid), 128'd0);
        chk("arst_s_ready", 128'(s_ready), 128'd1);
        chk("arst_rdata", PicoDataOut, 128'd0);
        tick(); tick();
        PicoRd = 1'b0; s_valid = 1'b0;
        PicoRst_n = 1'b1;
        tick();
        do_read(BASE + 32'h10, d); chk("status_arst", d, 128'h2_0000_0000);

        // randomized traffic, alternating stream bias to hit full and empty
        for (int n = 0; n < 3000; n++) begin
            automatic bit bias = ((n / 250) % 2) == 1;
            automatic int k = int'($urandom_range(0, 31));
            automatic logic [3:0] off;
            m_ready = bias ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
            s_valid = bias ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            s_data  = rand128();
            PicoDataIn = rand128();
            PicoWr = 1'($urandom_range(0, 1));
            PicoRd = ($urandom_range(0, 2) == 0);
            if      (k < 16) off = 4'h0;
            else if (k < 22) off = 4'h1;
            else if (k < 24) off = 4'h3;
            else if (k < 26) off = 4'h4;
            else if (k < 28) off = 4'h5;
            else if (k < 29) off = 4'h2;
            else             off = 4'hF;
            if (k >= 30) PicoAddr = 32'h0002_0000 | 32'($urandom_range(0, 255));
            else         PicoAddr = BASE | {24'd0, off, 4'($urandom_range(0, 15))};
            tick();
        end
        PicoWr = 1'b0; PicoRd = 1'b0; s_valid = 1'b0; m_ready = 1'b1;
        for (int i = 0; i < 20; i++) tick();

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end
endmodule
